// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types for the instruction-fetch queue
package fetch_pkg;

  localparam int FETCH_WIDTH = 2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_pair_fifo.sv
// rtl/fetch_pair_fifo.sv - circular queue with dual write and 0..2 entry pop
module fetch_pair_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_enq,
  input  fetch_entry_t i_wr0,
  input  fetch_entry_t i_wr1,
  input  logic [1:0]   i_pop_req,
  output fetch_entry_t o_rd0,
  output fetch_entry_t o_rd1,
  output logic [1:0]   o_valid,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [1:0]    w_req;
  logic [1:0]    w_pop;
  logic [AW-1:0] w_head1;
  logic [AW-1:0] w_tail1;
  logic [CW-1:0] w_count_next;

  // A request of 3 is clamped to 2, then limited to what is actually held.
  assign w_req        = (i_pop_req == 2'd3) ? 2'd2 : i_pop_req;
  assign w_pop        = (r_count < CW'(w_req)) ? r_count[1:0] : w_req;
  assign w_head1      = r_head + AW'(1);
  assign w_tail1      = r_tail + AW'(1);
  assign w_count_next = r_count + (i_enq ? CW'(2) : CW'(0)) - CW'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_enq) begin
        r_mem[r_tail]  <= i_wr0;
        r_mem[w_tail1] <= i_wr1;
        r_tail         <= r_tail + AW'(2);
      end
      r_head  <= r_head + AW'(w_pop);
      r_count <= w_count_next;
    end
  end

  assign o_rd0   = r_mem[r_head];
  assign o_rd1   = r_mem[w_head1];
  assign o_count = r_count;
  assign o_valid = (r_count == '0) ? 2'b00 :
                   (r_count == CW'(1)) ? 2'b01 : 2'b11;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - dual-issue fetch front end: PC, memory interface, redirect/stall control
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [31:0]                  Program_counter_IF,
  input  logic [FETCH_WIDTH-1:0][31:0] Instruction_IF,
  input  logic                         stall_IF,
  input  logic                         redirect_valid_IF,
  input  logic [31:0]                  redirect_pc_IF,
  input  logic [1:0]                   deq_count_IF,
  output logic [1:0]                   inst_valid_IF,
  output logic [FETCH_WIDTH-1:0][31:0] inst_IF,
  output logic [FETCH_WIDTH-1:0][31:0] inst_pc_IF,
  output logic [CW-1:0]                count_IF
);

  logic [31:0]  r_pc;
  logic         w_enq;
  fetch_entry_t w_wr0;
  fetch_entry_t w_wr1;
  fetch_entry_t w_rd0;
  fetch_entry_t w_rd1;

  // Room is judged on the pre-dequeue count; slots freed this cycle are not reused.
  assign w_enq = !redirect_valid_IF && !stall_IF && (count_IF <= CW'(DEPTH - 2));

  always_comb begin
    w_wr0      = '0;
    w_wr1      = '0;
    w_wr0.inst = Instruction_IF[0];
    w_wr0.pc   = r_pc;
    w_wr1.inst = Instruction_IF[1];
    w_wr1.pc   = r_pc + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid_IF) begin
      r_pc <= {redirect_pc_IF[31:2], 2'b00};
    end else if (w_enq) begin
      r_pc <= r_pc + 32'd8;
    end
  end

  fetch_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (redirect_valid_IF),
    .i_enq     (w_enq),
    .i_wr0     (w_wr0),
    .i_wr1     (w_wr1),
    .i_pop_req (deq_count_IF),
    .o_rd0     (w_rd0),
    .o_rd1     (w_rd1),
    .o_valid   (inst_valid_IF),
    .o_count   (count_IF)
  );

  assign Program_counter_IF = r_pc;
  assign inst_IF[0]         = w_rd0.inst;
  assign inst_IF[1]         = w_rd1.inst;
  assign inst_pc_IF[0]      = w_rd0.pc;
  assign inst_pc_IF[1]      = w_rd1.pc;

endmodule
